// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared definitions for the uart_tx arbiter slice: FSM state encoding,
// the header nibble, the ACK deadlock guard limit and a header-byte builder.
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_ACK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [3:0] HDR_NIBBLE      = 4'hA;
    localparam int         ACK_GUARD_LIMIT = 16;
    localparam int         ACK_GUARD_W     = 4;

    // Header byte announcing which requester owns the following frame.
    function automatic logic [7:0] hdr_byte(input logic [2:0] id);
        return {HDR_NIBBLE, 1'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if
// Bundle of NREQ byte-stream requesters feeding the arbiter.
//   req_valid[i]          byte valid from requester i
//   req_data[8i+7:8i]     byte from requester i
//   req_last[i]           final byte of the frame (qualified by req_valid)
//   req_ready[i]          byte taken when valid and ready meet on a clock edge
// master: the requesters; slave: the arbiter.
interface uart_tx_arb_if
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, output req_last, input req_ready);
    modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arb_rr_arb.sv
// rr_arb
// Round-robin winner select plus the rr pointer register.
//   fclk, rstn   clock, async active-low reset
//   req_valid    per-requester request
//   adv          pulse: the frame of adv_idx finished, move rr past it
//   adv_idx      index of the requester whose frame finished
//   win_found    some requester is valid
//   win_idx      lowest valid index at or after rr, wrapping
//   win_onehot   win_idx as a one-hot vector
module rr_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic            fclk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req_valid,
    input  logic            adv,
    input  logic [IDXW-1:0] adv_idx,
    output logic            win_found,
    output logic [IDXW-1:0] win_idx,
    output logic [NREQ-1:0] win_onehot
);
    localparam int CW = IDXW + 1;

    logic [IDXW-1:0] rr_r;

    // Scan candidates rr, rr+1, ... modulo NREQ; the first valid one wins.
    always_comb begin : scan_p
        logic [CW-1:0] cand;
        logic          hit;
        win_found = 1'b0;
        win_idx   = {IDXW{1'b0}};
        cand      = {CW{1'b0}};
        hit       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand      = {1'b0, rr_r} + CW'(k);
            cand      = (cand >= CW'(NREQ)) ? (cand - CW'(NREQ)) : cand;
            hit       = !win_found && req_valid[cand[IDXW-1:0]];
            win_idx   = hit ? cand[IDXW-1:0] : win_idx;
            win_found = win_found | req_valid[cand[IDXW-1:0]];
        end
    end

    assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

    // Pointer steps past the finished winner; untouched by clear.
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            rr_r <= {IDXW{1'b0}};
        end else if (adv) begin
            rr_r <= (adv_idx == IDXW'(NREQ - 1)) ? {IDXW{1'b0}} : (adv_idx + IDXW'(1));
        end else begin
            rr_r <= rr_r;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one uart_tx among NREQ byte-stream requesters. A winner is picked
// round-robin, locked until its last byte has gone out, and each byte (plus
// an optional header naming the winner) is pushed only when uart_tx is empty.
//   fclk, rstn   clock, async active-low reset
//   clear        synchronous abort back to IDLE (rr kept)
//   req          requester bundle (slave side)
//   tx_empty     uart_tx can take a byte
//   tx_push      one-cycle load strobe for tx_wdata
//   tx_wdata     byte presented to uart_tx
//   grant        one-hot current owner, zero when idle
//   busy         high whenever the FSM is not in IDLE
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int HDR_EN = 1
) (
    input  logic            fclk,
    input  logic            rstn,
    input  logic            clear,
    uart_tx_arb_if.slave    req,
    input  logic            tx_empty,
    output logic            tx_push,
    output logic [7:0]      tx_wdata,
    output logic [NREQ-1:0] grant,
    output logic            busy
);
    localparam int IDXW = $clog2(NREQ);

    state_t                 state_r;
    logic [NREQ-1:0]        grant_r;
    logic [IDXW-1:0]        gnt_idx_r;
    logic                   tx_push_r;
    logic [7:0]             tx_wdata_r;
    logic                   last_r;
    logic [ACK_GUARD_W-1:0] guard_r;

    logic                   win_found_s;
    logic [IDXW-1:0]        win_idx_s;
    logic [NREQ-1:0]        win_onehot_s;
    logic [7:0]             sel_byte_s;
    logic                   sel_last_s;
    logic                   sel_valid_s;
    logic                   accept_s;
    logic                   adv_s;

    rr_arb #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
        .fclk       (fclk),
        .rstn       (rstn),
        .req_valid  (req.req_valid),
        .adv        (adv_s),
        .adv_idx    (gnt_idx_r),
        .win_found  (win_found_s),
        .win_idx    (win_idx_s),
        .win_onehot (win_onehot_s)
    );

    // The only datapath: select the granted requester's byte and flags.
    assign sel_byte_s  = req.req_data[{gnt_idx_r, 3'b000} +: 8];
    assign sel_last_s  = req.req_last[gnt_idx_r];
    assign sel_valid_s = req.req_valid[gnt_idx_r];

    // Handshake happens in the same cycle the byte is captured; clear vetoes it.
    assign accept_s      = (state_r == ST_DATA) && sel_valid_s && tx_empty && !clear;
    assign req.req_ready = accept_s ? grant_r : {NREQ{1'b0}};
    assign adv_s         = (state_r == ST_DONE) && tx_empty && last_r && !clear;

    assign tx_push  = tx_push_r;
    assign tx_wdata = tx_wdata_r;
    assign grant    = grant_r;
    assign busy     = (state_r != ST_IDLE);

    // Frame FSM with registered push, byte, grant and ACK guard counter.
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NREQ{1'b0}};
            gnt_idx_r  <= {IDXW{1'b0}};
            tx_push_r  <= 1'b0;
            tx_wdata_r <= 8'h00;
            last_r     <= 1'b0;
            guard_r    <= {ACK_GUARD_W{1'b0}};
        end else if (clear) begin
            state_r   <= ST_IDLE;
            grant_r   <= {NREQ{1'b0}};
            tx_push_r <= 1'b0;
            last_r    <= 1'b0;
            guard_r   <= {ACK_GUARD_W{1'b0}};
        end else begin
            tx_push_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        grant_r   <= win_onehot_s;
                        gnt_idx_r <= win_idx_s;
                        state_r   <= (HDR_EN != 0) ? ST_HDR : ST_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (tx_empty) begin
                        tx_wdata_r <= hdr_byte(3'(gnt_idx_r));
                        last_r     <= 1'b0;     // a header always continues into DATA
                        tx_push_r  <= 1'b1;
                        guard_r    <= {ACK_GUARD_W{1'b0}};
                        state_r    <= ST_ACK;
                    end else begin
                        state_r <= ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        tx_wdata_r <= sel_byte_s;
                        last_r     <= sel_last_s;
                        tx_push_r  <= 1'b1;
                        guard_r    <= {ACK_GUARD_W{1'b0}};
                        state_r    <= ST_ACK;
                    end else begin
                        state_r <= ST_DATA;     // requester stalled: wait indefinitely
                    end
                end
                ST_ACK: begin
                    // Leave once uart_tx has taken the byte, or after the guard
                    // window so a transmitter that never drops tx_empty cannot hang us.
                    if (!tx_empty) begin
                        state_r <= ST_DONE;
                    end else if (guard_r == ACK_GUARD_W'(ACK_GUARD_LIMIT - 1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        guard_r <= guard_r + {{(ACK_GUARD_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (tx_empty) begin
                        if (last_r) begin
                            grant_r <= {NREQ{1'b0}};
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    grant_r <= {NREQ{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Directed bench for uart_tx_arb (NREQ=4, HDR_EN=1) with a small uart_tx
// model, per-requester byte queues and a log of every pushed byte.
module tb_uart_tx_arb;
    import uart_tx_arb_pkg::*;

    localparam int NREQ = 4;

    logic       fclk = 1'b0;
    logic       rstn;
    logic       clear;
    logic       tx_empty = 1'b1;
    logic       tx_push;
    logic [7:0] tx_wdata;
    logic [3:0] grant;
    logic       busy;

    uart_tx_arb_if #(.NREQ(NREQ)) rq ();

    uart_tx_arb #(.NREQ(NREQ), .HDR_EN(1)) dut (
        .fclk     (fclk),
        .rstn     (rstn),
        .clear    (clear),
        .req      (rq),
        .tx_empty (tx_empty),
        .tx_push  (tx_push),
        .tx_wdata (tx_wdata),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 fclk = ~fclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int illegal = 0;
    int ubusy = 0;
    logic stall = 1'b0;

    logic [7:0] plog [$];
    logic [3:0] pgnt [$];
    int         pcyc [$];

    logic [8:0]      rmem [NREQ][16];
    int              head [NREQ] = '{default: 0};
    int              tail [NREQ] = '{default: 0};
    int              vcyc [NREQ] = '{default: 0};
    logic [NREQ-1:0] hold = '0;
    logic [NREQ-1:0] acc  = '0;

    // Cycle counter.
    always @(posedge fclk) cyc <= cyc + 1;

    // uart_tx model: busy for 3 cycles per byte, or never busy when stalled.
    always @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            tx_empty <= 1'b1;
            ubusy    <= 0;
        end else if (tx_push && !stall) begin
            tx_empty <= 1'b0;
            ubusy    <= 3;
        end else if (ubusy > 0) begin
            ubusy <= ubusy - 1;
            if (ubusy == 1) tx_empty <= 1'b1;
        end
    end

    // Push log, sampled mid-cycle.
    always @(negedge fclk) begin
        if (rstn && tx_push) begin
            plog.push_back(tx_wdata);
            pgnt.push_back(grant);
            pcyc.push_back(cyc);
            if (!tx_empty) illegal <= illegal + 1;
        end
    end

    // Handshake sampled on the active edge.
    always @(posedge fclk) acc = rq.req_valid & rq.req_ready;

    // Requesters: pop accepted bytes, present the queue head.
    always @(negedge fclk) begin
        for (int i = 0; i < NREQ; i++) begin
            logic v;
            if (acc[i]) head[i] = head[i] + 1;
            v = (head[i] != tail[i]) && !hold[i];
            if (v && !rq.req_valid[i]) vcyc[i] = cyc;
            rq.req_valid[i]        = v;
            rq.req_data[8*i +: 8]  = rmem[i][head[i] % 16][7:0];
            rq.req_last[i]         = rmem[i][head[i] % 16][8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic enq(input int id, input logic [7:0] d, input logic l);
        rmem[id][tail[id] % 16] = {l, d};
        tail[id] = tail[id] + 1;
    endtask

    task automatic chk_push(input string tag, input int idx, input logic [7:0] eb, input logic [3:0] eg);
        if (idx < plog.size()) begin
            check_eq({tag, "_byte"}, 32'(plog[idx]), 32'(eb));
            check_eq({tag, "_gnt"}, 32'(pgnt[idx]), 32'(eg));
        end else begin
            check_eq({tag, "_missing"}, 32'(plog.size()), 32'(idx + 1));
        end
    endtask

    task automatic wait_pushes(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (plog.size() < n && k < budget) begin
            @(negedge fclk); #1;
            k++;
        end
        check_eq({tag, "_npush"}, 32'(plog.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge fclk); #1;
            k++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int base;
        int k;
        logic hit;
        logic rdy0_seen;
        logic gnt_bad;

        rstn  = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge fclk);
        #1;
        check_eq("rst_grant", 32'(grant), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_push", 32'(tx_push), 32'(0));
        check_eq("rst_wdata", 32'(tx_wdata), 32'(0));
        check_eq("rst_ready", 32'(rq.req_ready), 32'(0));
        check_eq("rst_rr", 32'(dut.u_rr.rr_r), 32'(0));
        check_eq("rst_guard", 32'(dut.guard_r), 32'(0));
        rstn = 1'b1;

        // Single requester 2 sends 55 with last.
        base = plog.size();
        enq(2, 8'h55, 1'b1);
        wait_pushes("t1", base + 2, 100);
        wait_idle("t1", 100);
        chk_push("t1_hdr", base, 8'hA2, 4'b0100);
        chk_push("t1_dat", base + 1, 8'h55, 4'b0100);
        if (plog.size() > base) check_eq("t1_latency", 32'(pcyc[base] - vcyc[2]), 32'(2));
        check_eq("t1_grant_end", 32'(grant), 32'(0));
        check_eq("t1_rr", 32'(dut.u_rr.rr_r), 32'(3));

        // Back to rr=0, then all four request together.
        @(negedge fclk); #1;
        rstn = 1'b0;
        @(negedge fclk); #1;
        rstn = 1'b1;
        check_eq("t2_rr0", 32'(dut.u_rr.rr_r), 32'(0));
        base = plog.size();
        for (int i = 0; i < NREQ; i++) enq(i, 8'h10 + 8'(i), 1'b1);
        wait_pushes("t2", base + 8, 400);
        wait_idle("t2", 100);
        for (int i = 0; i < NREQ; i++) begin
            chk_push($sformatf("t2_hdr%0d", i), base + 2*i, 8'hA0 + 8'(i), 4'(1 << i));
            chk_push($sformatf("t2_dat%0d", i), base + 2*i + 1, 8'h10 + 8'(i), 4'(1 << i));
        end

        // Requester 1 stalls 5 cycles mid-frame; requester 0 waits meanwhile.
        base = plog.size();
        enq(1, 8'h31, 1'b0);
        wait_pushes("t3a", base + 2, 100);
        enq(0, 8'h07, 1'b1);
        rdy0_seen = 1'b0;
        gnt_bad   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge fclk); #1;
            if (rq.req_ready[0]) rdy0_seen = 1'b1;
            if (grant != 4'b0010) gnt_bad = 1'b1;
        end
        check_eq("t3_stall_push", 32'(plog.size()), 32'(base + 2));
        check_eq("t3_stall_gnt", 32'(gnt_bad), 32'(0));
        check_eq("t3_no_rdy0", 32'(rdy0_seen), 32'(0));
        enq(1, 8'h32, 1'b0);
        enq(1, 8'h33, 1'b1);
        wait_pushes("t3b", base + 6, 300);
        wait_idle("t3", 100);
        chk_push("t3_hdr", base, 8'hA1, 4'b0010);
        chk_push("t3_b1", base + 1, 8'h31, 4'b0010);
        chk_push("t3_b2", base + 2, 8'h32, 4'b0010);
        chk_push("t3_b3", base + 3, 8'h33, 4'b0010);
        chk_push("t3_hdr0", base + 4, 8'hA0, 4'b0001);
        chk_push("t3_r0", base + 5, 8'h07, 4'b0001);

        // clear while in DONE after byte 2 of requester 2.
        base = plog.size();
        enq(2, 8'h41, 1'b0);
        enq(2, 8'h42, 1'b0);
        enq(2, 8'h43, 1'b1);
        hit = 1'b0;
        k = 0;
        while (!hit && k < 200) begin
            @(negedge fclk); #1;
            hit = (dut.state_r == ST_DONE) && (plog.size() == base + 3);
            k++;
        end
        check_eq("t4_reach_done", 32'(hit), 32'(1));
        clear = 1'b1;
        @(negedge fclk); #1;
        clear = 1'b0;
        check_eq("t4_state", 32'(dut.state_r), 32'(ST_IDLE));
        check_eq("t4_grant", 32'(grant), 32'(0));
        check_eq("t4_busy", 32'(busy), 32'(0));
        check_eq("t4_rr", 32'(dut.u_rr.rr_r), 32'(1));
        check_eq("t4_nopush", 32'(plog.size()), 32'(base + 3));
        wait_pushes("t4", base + 5, 200);
        wait_idle("t4", 100);
        chk_push("t4_b2", base + 2, 8'h42, 4'b0100);
        chk_push("t4_rehdr", base + 3, 8'hA2, 4'b0100);
        chk_push("t4_b3", base + 4, 8'h43, 4'b0100);

        // uart_tx never drops tx_empty: guard releases ACK after 16 cycles.
        stall = 1'b1;
        base = plog.size();
        enq(0, 8'h66, 1'b1);
        wait_pushes("t5", base + 2, 200);
        wait_idle("t5", 100);
        chk_push("t5_hdr", base, 8'hA0, 4'b0001);
        chk_push("t5_dat", base + 1, 8'h66, 4'b0001);
        if (plog.size() >= base + 2) check_eq("t5_spacing", 32'(pcyc[base + 1] - pcyc[base]), 32'(18));
        stall = 1'b0;

        // Reset in the middle of a frame, requester 3 stalled in DATA.
        base = plog.size();
        enq(3, 8'h71, 1'b0);
        hit = 1'b0;
        k = 0;
        while (!hit && k < 200) begin
            @(negedge fclk); #1;
            hit = (dut.state_r == ST_DATA) && (plog.size() == base + 2);
            k++;
        end
        check_eq("t6_reach_data", 32'(hit), 32'(1));
        check_eq("t6_rr_pre", 32'(dut.u_rr.rr_r), 32'(1));
        rstn = 1'b0;
        #1;
        check_eq("t6_grant", 32'(grant), 32'(0));
        check_eq("t6_busy", 32'(busy), 32'(0));
        check_eq("t6_push", 32'(tx_push), 32'(0));
        check_eq("t6_wdata", 32'(tx_wdata), 32'(0));
        check_eq("t6_ready", 32'(rq.req_ready), 32'(0));
        check_eq("t6_rr", 32'(dut.u_rr.rr_r), 32'(0));
        @(negedge fclk); #1;
        rstn = 1'b1;
        repeat (5) @(negedge fclk);
        #1;
        check_eq("t6_nopush", 32'(plog.size()), 32'(base + 2));
        check_eq("t6_rr_after", 32'(dut.u_rr.rr_r), 32'(0));
        check_eq("t6_idle", 32'(busy), 32'(0));

        check_eq("push_while_busy", 32'(illegal), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
